// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: one single-ported, variable-latency memory shared by
// instruction fetch and data access. Data side has priority. At most one
// transaction is outstanding. A completed fetch is buffered while F is stalled,
// and a fetch killed by a redirect is discarded.
module unified_mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_kill,
  input  logic          f_advance,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          stall_f,
  output logic          stall_m,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ibuf_valid_q, ibuf_valid_d;
  logic [DW-1:0] ibuf_q, ibuf_d;
  logic          kill_pend_q, kill_pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // State, fetch buffer, kill tracking and accepted-request registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      ibuf_valid_q <= 1'b0;
      ibuf_q       <= '0;
      kill_pend_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_q       <= ibuf_d;
      kill_pend_q  <= kill_pend_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next-state, memory request sequencing and response steering
  always_comb begin
    state_d      = state_q;
    ibuf_d       = ibuf_q;
    kill_pend_d  = kill_pend_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    // Buffered fetch is consumed by an F advance or dropped by a redirect
    ibuf_valid_d = ibuf_valid_q & ~f_advance & ~i_kill;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    i_valid      = ibuf_valid_q & ~i_kill;
    i_rdata      = ibuf_valid_q ? ibuf_q : '0;
    d_valid      = 1'b0;
    d_rdata      = '0;

    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          mem_req   = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          if (mem_ready) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            state_d = DBUSY;
          end
        end else if (i_req && !ibuf_valid_q && !i_kill) begin
          mem_req   = 1'b1;
          mem_addr  = i_addr;
          mem_wdata = '0;
          if (mem_ready) begin
            addr_d      = i_addr;
            wdata_d     = '0;
            kill_pend_d = 1'b0;
            state_d     = IBUSY;
          end
        end
      end
      DBUSY: begin
        if (mem_rvalid) begin
          d_valid = 1'b1;
          d_rdata = mem_rdata;
          state_d = IDLE;
        end
      end
      IBUSY: begin
        kill_pend_d = kill_pend_q | i_kill;
        if (mem_rvalid) begin
          if (!(kill_pend_q || i_kill)) begin
            i_valid = 1'b1;
            i_rdata = mem_rdata;
            if (!f_advance) begin
              ibuf_d       = mem_rdata;
              ibuf_valid_d = 1'b1;
            end
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_f = i_req & ~i_valid;
    stall_m = d_req & ~d_valid;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed cycle table covering the corner
// sequences, then random traffic against a transaction-level reference model.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_kill, f_advance, i_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        stall_f, stall_m;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  unified_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .f_advance(f_advance),
    .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit ireq; logic [31:0] iaddr; bit ikill; bit fadv;
    bit dreq; bit dwe; logic [31:0] daddr; logic [31:0] dwdata;
    bit rdy; bit rv; logic [31:0] rdata;
    bit emreq; bit emwe; logic [31:0] emaddr; logic [31:0] emwdata;
    bit eiv; logic [31:0] eird; bit edv; logic [31:0] edrd; bit esf; bit esm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input bit rst, input bit ireq, input logic [31:0] iaddr, input bit ikill, input bit fadv,
    input bit dreq, input bit dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
    input bit rdy, input bit rv, input logic [31:0] rdata,
    input bit emreq, input bit emwe, input logic [31:0] emaddr, input logic [31:0] emwdata,
    input bit eiv, input logic [31:0] eird, input bit edv, input logic [31:0] edrd,
    input bit esf, input bit esm);
    vec_t r;
    r.rst = rst; r.ireq = ireq; r.iaddr = iaddr; r.ikill = ikill; r.fadv = fadv;
    r.dreq = dreq; r.dwe = dwe; r.daddr = daddr; r.dwdata = dwdata;
    r.rdy = rdy; r.rv = rv; r.rdata = rdata;
    r.emreq = emreq; r.emwe = emwe; r.emaddr = emaddr; r.emwdata = emwdata;
    r.eiv = eiv; r.eird = eird; r.edv = edv; r.edrd = edrd; r.esf = esf; r.esm = esm;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input vec_t x);
    reset = x.rst; i_req = x.ireq; i_addr = x.iaddr; i_kill = x.ikill; f_advance = x.fadv;
    d_req = x.dreq; d_we = x.dwe; d_addr = x.daddr; d_wdata = x.dwdata;
    mem_ready = x.rdy; mem_rvalid = x.rv; mem_rdata = x.rdata;
  endtask

  // Reference model: one pending-transaction record plus the fetch buffer
  bit          m_pv, m_pd, m_pw, m_pk, m_bv;
  logic [31:0] m_bd;

  initial begin
    // rst ireq iaddr ikill fadv | dreq dwe daddr dwdata | rdy rv rdata | emreq emwe emaddr emwdata | eiv eird edv edrd esf esm
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0));                                 // 0 reset, idle
    tbl.push_back(v(1,0,0,0,0, 1,0,32'h40,0, 1,0,0, 1,0,32'h40,0, 0,0,0,0, 0,1));                       // 1 load issue
    tbl.push_back(v(1,0,0,0,0, 1,0,32'h40,0, 1,1,32'hDEADBEEF, 0,0,0,0, 0,0,1,32'hDEADBEEF, 0,0));       // 2 load done
    tbl.push_back(v(1,1,32'h200,0,0, 1,1,32'h80,32'h12345678, 1,0,0, 1,1,32'h80,32'h12345678, 0,0,0,0, 1,1)); // 3 contention
    tbl.push_back(v(1,1,32'h200,0,0, 1,1,32'h80,32'h12345678, 1,1,0, 0,0,0,0, 0,0,1,0, 1,0));            // 4 store ack
    tbl.push_back(v(1,1,32'h200,0,0, 0,0,0,0, 1,0,0, 1,0,32'h200,0, 0,0,0,0, 1,0));                     // 5 fetch issue
    tbl.push_back(v(1,1,32'h200,0,0, 0,0,0,0, 1,1,32'hE2811001, 0,0,0,0, 1,32'hE2811001,0,0, 0,0));      // 6 resp, stalled
    tbl.push_back(v(1,1,32'h200,0,0, 0,0,0,0, 1,0,0, 0,0,0,0, 1,32'hE2811001,0,0, 0,0));                 // 7 buffered
    tbl.push_back(v(1,1,32'h200,0,0, 0,0,0,0, 1,0,0, 0,0,0,0, 1,32'hE2811001,0,0, 0,0));                 // 8 buffered
    tbl.push_back(v(1,1,32'h200,0,1, 0,0,0,0, 1,0,0, 0,0,0,0, 1,32'hE2811001,0,0, 0,0));                 // 9 advance
    tbl.push_back(v(1,1,32'h204,0,0, 0,0,0,0, 1,0,0, 1,0,32'h204,0, 0,0,0,0, 1,0));                     // 10 next fetch
    tbl.push_back(v(1,1,32'h300,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 1,0));                           // 11 kill
    tbl.push_back(v(1,1,32'h300,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 1,0));                           // 12 wait
    tbl.push_back(v(1,1,32'h300,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 1,0));                           // 13 wait
    tbl.push_back(v(1,1,32'h300,0,1, 0,0,0,0, 0,1,32'h11111111, 0,0,0,0, 0,0,0,0, 1,0));                // 14 discarded
    tbl.push_back(v(1,1,32'h300,0,0, 0,0,0,0, 1,0,0, 1,0,32'h300,0, 0,0,0,0, 1,0));                     // 15 redirect fetch
    tbl.push_back(v(1,1,32'h300,0,1, 0,0,0,0, 0,1,32'h22222222, 0,0,0,0, 1,32'h22222222,0,0, 0,0));      // 16 live resp
    tbl.push_back(v(1,0,0,0,0, 1,0,32'h44,0, 1,0,0, 1,0,32'h44,0, 0,0,0,0, 0,1));                       // 17 load issue
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0));                                 // 18 reset in DBUSY
    tbl.push_back(v(1,0,0,0,0, 0,0,0,0, 0,1,32'h33, 0,0,0,0, 0,0,0,0, 0,0));                            // 19 late rvalid
    for (int k = 0; k < 5; k++)
      tbl.push_back(v(1,0,0,0,0, 1,0,32'h48,0, 0,0,0, 1,0,32'h48,0, 0,0,0,0, 0,1));                     // 20-24 not ready
    tbl.push_back(v(1,0,0,0,0, 1,0,32'h48,0, 1,0,0, 1,0,32'h48,0, 0,0,0,0, 0,1));                       // 25 accepted
    tbl.push_back(v(1,0,0,0,0, 1,0,32'h48,0, 0,1,32'h5555AAAA, 0,0,0,0, 0,0,1,32'h5555AAAA, 0,0));       // 26 done
    tbl.push_back(v(1,1,32'h400,0,0, 0,0,0,0, 1,0,0, 1,0,32'h400,0, 0,0,0,0, 1,0));                     // 27 fetch
    tbl.push_back(v(1,1,32'h400,0,0, 0,0,0,0, 0,1,32'h66, 0,0,0,0, 1,32'h66,0,0, 0,0));                 // 28 buffered
    tbl.push_back(v(1,1,32'h500,1,0, 0,0,0,0, 1,0,0, 0,0,0,0, 0,0,0,0, 1,0));                           // 29 kill + buffer
    tbl.push_back(v(1,1,32'h500,0,0, 0,0,0,0, 1,0,0, 1,0,32'h500,0, 0,0,0,0, 1,0));                     // 30 refetch
    tbl.push_back(v(1,1,32'h500,0,1, 0,0,0,0, 0,1,32'h77, 0,0,0,0, 1,32'h77,0,0, 0,0));                 // 31 live
    tbl.push_back(v(1,1,32'h504,0,0, 0,0,0,0, 1,0,0, 1,0,32'h504,0, 0,0,0,0, 1,0));                     // 32 fetch
    tbl.push_back(v(1,1,32'h504,0,0, 1,0,32'h4C,0, 1,1,32'h88, 0,0,0,0, 1,32'h88,0,0, 0,1));            // 33 d_req in IBUSY
    tbl.push_back(v(1,1,32'h504,0,0, 1,0,32'h4C,0, 1,0,0, 1,0,32'h4C,0, 1,32'h88,0,0, 0,1));            // 34 data issues
    tbl.push_back(v(1,1,32'h504,0,1, 1,0,32'h4C,0, 0,1,32'h99, 0,0,0,0, 1,32'h88,1,32'h99, 0,0));        // 35 data done

    drive(v(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
    repeat (2) @(negedge clk);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k]);
      #1;
      chk1($sformatf("row%0d_mem_req", k), mem_req, tbl[k].emreq);
      if (tbl[k].emreq) begin
        chk1($sformatf("row%0d_mem_we", k), mem_we, tbl[k].emwe);
        chk($sformatf("row%0d_mem_addr", k), mem_addr, tbl[k].emaddr);
        if (tbl[k].emwe) chk($sformatf("row%0d_mem_wdata", k), mem_wdata, tbl[k].emwdata);
      end
      chk1($sformatf("row%0d_i_valid", k), i_valid, tbl[k].eiv);
      if (tbl[k].eiv) chk($sformatf("row%0d_i_rdata", k), i_rdata, tbl[k].eird);
      chk1($sformatf("row%0d_d_valid", k), d_valid, tbl[k].edv);
      if (tbl[k].edv && !tbl[k].dwe) chk($sformatf("row%0d_d_rdata", k), d_rdata, tbl[k].edrd);
      chk1($sformatf("row%0d_stall_f", k), stall_f, tbl[k].esf);
      chk1($sformatf("row%0d_stall_m", k), stall_m, tbl[k].esm);
    end

    // Random traffic: start from a reset cycle so model and DUT agree
    @(negedge clk);
    drive(v(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
    m_pv = 0; m_pd = 0; m_pw = 0; m_pk = 0; m_bv = 0; m_bd = '0;

    for (int c = 0; c < 3000; c++) begin
      bit live, iss_d, iss_i, x_iv, x_dv, x_mreq;
      logic [31:0] x_ird, x_maddr;
      @(negedge clk);
      reset      = ($urandom_range(0, 63) != 0);
      i_req      = ($urandom_range(0, 3) != 0);
      i_addr     = $urandom;
      i_kill     = ($urandom_range(0, 9) == 0);
      f_advance  = $urandom_range(0, 1) == 1;
      d_req      = ($urandom_range(0, 2) == 0);
      d_we       = $urandom_range(0, 1) == 1;
      d_addr     = $urandom;
      d_wdata    = $urandom;
      mem_ready  = ($urandom_range(0, 4) != 0);
      mem_rvalid = ($urandom_range(0, 1) == 1);
      mem_rdata  = $urandom;
      #1;
      live    = m_pv && !m_pd && mem_rvalid && !m_pk && !i_kill;
      x_iv    = (m_bv && !i_kill) || live;
      x_ird   = m_bv ? m_bd : mem_rdata;
      x_dv    = m_pv && m_pd && mem_rvalid;
      iss_d   = !m_pv && d_req;
      iss_i   = !m_pv && !d_req && i_req && !m_bv && !i_kill;
      x_mreq  = iss_d || iss_i;
      x_maddr = iss_d ? d_addr : i_addr;
      chk1($sformatf("rnd%0d_mem_req", c), mem_req, x_mreq);
      if (x_mreq) begin
        chk1($sformatf("rnd%0d_mem_we", c), mem_we, iss_d && d_we);
        chk($sformatf("rnd%0d_mem_addr", c), mem_addr, x_maddr);
        if (iss_d && d_we) chk($sformatf("rnd%0d_mem_wdata", c), mem_wdata, d_wdata);
      end
      chk1($sformatf("rnd%0d_i_valid", c), i_valid, x_iv);
      if (x_iv) chk($sformatf("rnd%0d_i_rdata", c), i_rdata, x_ird);
      chk1($sformatf("rnd%0d_d_valid", c), d_valid, x_dv);
      if (x_dv && !m_pw) chk($sformatf("rnd%0d_d_rdata", c), d_rdata, mem_rdata);
      chk1($sformatf("rnd%0d_stall_f", c), stall_f, i_req && !x_iv);
      chk1($sformatf("rnd%0d_stall_m", c), stall_m, d_req && !x_dv);

      // Advance the model to the state after this clock edge
      if (!reset) begin
        m_pv = 0; m_pk = 0; m_bv = 0; m_bd = '0;
      end else begin
        if (m_bv && (f_advance || i_kill)) m_bv = 0;
        if (m_pv && !m_pd && i_kill) m_pk = 1;
        if (m_pv) begin
          if (mem_rvalid) begin
            if (live && !f_advance) begin m_bv = 1; m_bd = mem_rdata; end
            m_pv = 0;
          end
        end else if (x_mreq && mem_ready) begin
          m_pv = 1; m_pd = iss_d; m_pw = iss_d && d_we; m_pk = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
